// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: two requesters share one memory read port through an IDLE/READ/WAIT FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_read_arbiter #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic [31:0]   m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    output logic [31:0]   m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rstrb,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_rstrb_q, mem_rstrb_d;
    logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
    logic            m0_rvalid_q, m0_rvalid_d;
    logic            m1_rvalid_q, m1_rvalid_d;
    logic            busy_q, busy_d;
    logic            win_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic            last_q, last_d;

    // On a tie the port not granted last wins; a lone request always wins.
    assign win_c = (m0_req && m1_req) ? ~last_q : ~m0_req;
`else
    assign win_c = ~m0_req;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_rstrb_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d       = win_c;
                    mem_addr_d  = win_c ? m1_addr : m0_addr;
                    mem_rstrb_d = 1'b1;
                    state_d     = READ;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d      = win_c;
`endif
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = IDLE;
                if (gnt_q) begin
                    m1_rdata_d  = mem_rdata;
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = mem_rdata;
                    m0_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_rstrb_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_rstrb_q <= mem_rstrb_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rstrb = mem_rstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: randomized and directed checks of mem_read_arbiter against a
// transaction-schedule model (grant at edge k -> strobe in k, busy k..k+1, rvalid in k+2).
module tb_mem_read_arbiter;

    localparam int unsigned AW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          m0_rvalid, m1_rvalid;
    logic [AW-1:0] mem_addr;
    logic          mem_rstrb;
    logic [31:0]   mem_rdata = '0;
    logic          busy;

    mem_read_arbiter #(.AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          cmp_en = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: data for the strobed address appears the cycle after the strobe, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_rstrb ? memf(mem_addr) : $urandom;

    // Reference model: schedule of expected outputs per cycle, kept in an 8-entry ring.
    int unsigned cyc = 0, next_free = 0;
    logic [7:0]  s_strb = '0, s_busy = '0, s_rv0 = '0, s_rv1 = '0;
    logic [31:0] s_data [8];
    logic [31:0] e_addr = '0, e_rd0 = '0, e_rd1 = '0;
    logic        e_last = 1'b1;
    logic [2:0]  m_sl;
    logic        m_w;
    logic [31:0] m_a;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc = 0; next_free = 0;
            s_strb = '0; s_busy = '0; s_rv0 = '0; s_rv1 = '0;
            e_addr = '0; e_rd0 = '0; e_rd1 = '0; e_last = 1'b1;
        end else begin
            cyc++;
            m_sl = 3'(cyc);
            s_strb[3'(cyc + 7)] = 1'b0;
            s_busy[3'(cyc + 7)] = 1'b0;
            s_rv0[3'(cyc + 7)]  = 1'b0;
            s_rv1[3'(cyc + 7)]  = 1'b0;
            if (s_rv0[m_sl]) e_rd0 = s_data[m_sl];
            if (s_rv1[m_sl]) e_rd1 = s_data[m_sl];
            if (cyc >= next_free && (m0_req || m1_req)) begin
                if (m0_req && m1_req) m_w = RR_EN ? ~e_last : 1'b0;
                else                  m_w = m1_req;
                m_a = m_w ? m1_addr : m0_addr;
                s_strb[m_sl] = 1'b1;
                s_busy[m_sl] = 1'b1;
                s_busy[3'(cyc + 1)] = 1'b1;
                if (m_w) s_rv1[3'(cyc + 2)] = 1'b1;
                else     s_rv0[3'(cyc + 2)] = 1'b1;
                s_data[3'(cyc + 2)] = memf(m_a);
                e_addr = m_a;
                e_last = m_w;
                next_free = cyc + 3;
            end
        end
    end

    logic [2:0] c_sl;
    always @(negedge clk) begin
        if (cmp_en) begin
            c_sl = 3'(cyc);
            chk("mem_rstrb", 32'(mem_rstrb), 32'(s_strb[c_sl]));
            chk("mem_addr",  mem_addr,       e_addr);
            chk("busy",      32'(busy),      32'(s_busy[c_sl]));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(s_rv0[c_sl]));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(s_rv1[c_sl]));
            chk("m0_rdata",  m0_rdata,       e_rd0);
            chk("m1_rdata",  m1_rdata,       e_rd1);
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        resetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk); #2;
        resetn = 1'b1;
    endtask

    task automatic wait_rv(input bit port, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(budget); i++) begin
            @(negedge clk);
            if ((port ? m1_rvalid : m0_rvalid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] raddr();
        return $urandom & 32'h0000_FFFC;
    endfunction

    initial begin
        bit          ok;
        int unsigned n_rv;
        logic [3:0]  order;
        logic [3:0]  exp_order;
        int unsigned t_prev;
        logic [31:0] addrs [3];

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_strb",   32'(mem_rstrb), 32'd0);
        chk("rst_addr",   mem_addr,       32'd0);
        chk("rst_m1data", m1_rdata,       32'd0);
        #2 resetn = 1'b1;

        // Single m0 read at 0x10.
        @(negedge clk); m0_req = 1'b1; m0_addr = 32'h10;
        @(negedge clk);
        chk("t29_strb", 32'(mem_rstrb), 32'd1);
        chk("t29_addr", mem_addr,       32'h10);
        chk("t29_busy", 32'(busy),      32'd1);
        @(negedge clk);
        chk("t29_rv_early", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        chk("t29_rv",     32'(m0_rvalid), 32'd1);
        chk("t29_rdata",  m0_rdata,       32'hDEAD_BEEF);
        chk("t29_m1data", m1_rdata,       32'd0);
        chk("t29_m1rv",   32'(m1_rvalid), 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        chk("t29_rv_after", 32'(m0_rvalid), 32'd0);
        chk("t29_idle",     32'(busy),      32'd0);

        // Simultaneous requests held for four reads.
        do_reset();
        @(negedge clk); m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
        n_rv = 0; order = '0;
        exp_order = RR_EN ? 4'b1010 : 4'b0000;
        for (int i = 0; i < 40 && n_rv < 4; i++) begin
            @(negedge clk);
            if (m0_rvalid === 1'b1) begin order[n_rv[1:0]] = 1'b0; n_rv++; end
            else if (m1_rvalid === 1'b1) begin order[n_rv[1:0]] = 1'b1; n_rv++; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t30_count", n_rv, 32'd4);
        for (int i = 0; i < 4; i++) chk("t30_order", 32'(order[i]), 32'(exp_order[i]));

        // m1 back-to-back reads.
        do_reset();
        addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
        @(negedge clk); m1_req = 1'b1; m1_addr = addrs[0];
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rv(1'b1, 12, ok);
            chk("t31_timeout", 32'(ok), 32'd1);
            chk("t31_data", m1_rdata, memf(addrs[i]));
            if (i > 0) chk("t31_spacing", cyc - t_prev, 32'd3);
            t_prev = cyc;
            if (i < 2) m1_addr = addrs[i + 1];
            else       m1_req = 1'b0;
        end

        // Reset during WAIT abandons the read.
        @(negedge clk); m0_req = 1'b1; m0_addr = 32'h30;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b0; m0_req = 1'b0;
        #1;
        chk("t32_strb",   32'(mem_rstrb), 32'd0);
        chk("t32_addr",   mem_addr,       32'd0);
        chk("t32_m0rv",   32'(m0_rvalid), 32'd0);
        chk("t32_m1rv",   32'(m1_rvalid), 32'd0);
        chk("t32_m0data", m0_rdata,       32'd0);
        chk("t32_m1data", m1_rdata,       32'd0);
        chk("t32_busy",   32'(busy),      32'd0);
        @(negedge clk); #2 resetn = 1'b1;
        n_rv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) n_rv++;
        end
        chk("t32_no_rv", n_rv, 32'd0);

        // Address change after grant is ignored.
        do_reset();
        @(negedge clk); m0_req = 1'b1; m0_addr = 32'h20;
        @(negedge clk); m0_addr = 32'h40;
        chk("t33_addr", mem_addr, 32'h20);
        @(negedge clk);
        chk("t33_addr_hold", mem_addr, 32'h20);
        @(negedge clk);
        chk("t33_rv",    32'(m0_rvalid), 32'd1);
        chk("t33_rdata", m0_rdata,       memf(32'h20));
        m0_req = 1'b0;

        // Randomized traffic with a mid-run reset.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (i == 600) begin
                #2 resetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
                @(negedge clk); #2 resetn = 1'b1;
                continue;
            end
            if (m0_req && m0_rvalid) begin
                if ($urandom_range(2) != 0) m0_req = 1'b0;
                else                        m0_addr = raddr();
            end else if (!m0_req && $urandom_range(3) == 0) begin
                m0_req = 1'b1; m0_addr = raddr();
            end else if (m0_req && $urandom_range(7) == 0) begin
                m0_addr = raddr();
            end
            if (m1_req && m1_rvalid) begin
                if ($urandom_range(2) != 0) m1_req = 1'b0;
                else                        m1_addr = raddr();
            end else if (!m1_req && $urandom_range(3) == 0) begin
                m1_req = 1'b1; m1_addr = raddr();
            end else if (m1_req && $urandom_range(7) == 0) begin
                m1_addr = raddr();
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_rvalid === 1'b1) m0_req = 1'b0;
            if (m1_rvalid === 1'b1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (5) @(negedge clk);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requester ports and of the memory port.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: m0_req  input  1  requester 0 read request; held high until m0_rvalid.
REQ-005 Port: m0_addr  input  AW  requester 0 byte address; stable while m0_req is high.
REQ-006 Port: m0_rdata  output  32  requester 0 read data, registered.
REQ-007 Port: m0_rvalid  output  1  one-cycle pulse; m0_rdata is valid in this cycle.
REQ-008 Ports: m1_req, m1_addr, m1_rdata, m1_rvalid, with the same directions, widths and meanings for requester 1.
REQ-009 Port: mem_addr  output  AW  address to the shared memory, registered.
REQ-010 Port: mem_rstrb  output  1  memory read strobe, one-cycle pulse.
REQ-011 Port: mem_rdata  input  32  memory read data, valid one cycle after mem_rstrb.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states are IDLE, READ and WAIT; IDLE is the only state that accepts requests.
REQ-014 IDLE with any req high -> latch the winner's index into gnt and its address into mem_addr, then go to READ; IDLE with no req stays in IDLE.
REQ-015 READ: mem_rstrb=1 for exactly this cycle, mem_addr holds the latched address, next state WAIT.
REQ-016 WAIT: capture mem_rdata into m<gnt>_rdata, set m<gnt>_rvalid=1 for the next cycle only, then go to IDLE.
REQ-017 Latency: req first high in cycle N, port granted -> rvalid high in cycle N+3; throughput is one read per 3 cycles.
REQ-018 Only one of m0_rvalid or m1_rvalid is high in any cycle; the loser's rdata register is never modified.
REQ-019 A req sampled high in the cycle its rvalid is high counts as a new request, so holding req continuously yields back-to-back reads.
REQ-020 mem_addr and m*_addr changes after the grant are ignored until the next IDLE.
REQ-021 mem_rstrb is never asserted outside READ.
REQ-022 An m*_req deasserted before rvalid is a protocol violation; the arbiter still completes the read and pulses rvalid.

Reset
REQ-023 On resetn low the block immediately and asynchronously enters state IDLE.
REQ-024 On resetn low: mem_rstrb=0, mem_addr=0, m0_rvalid=0, m1_rvalid=0, m0_rdata=0, m1_rdata=0, busy=0, gnt=0, last=1.
REQ-025 A reset during READ or WAIT abandons the transaction: no rvalid is issued and no rdata is updated.
REQ-026 After resetn rises, the first rising edge with a req high starts a grant per REQ-014.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: when both req are high in IDLE, the port not granted last (register last, updated on every grant) wins; a single req always wins.
REQ-028 ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties, and the last register is not implemented.

Verification
REQ-029 Single m0 read at 0x0000_0010 with memory returning 0xDEADBEEF -> mem_rstrb pulses in cycle N+1 with mem_addr=0x10, then m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle N+3, while m1_rdata stays 0.
REQ-030 m0 and m1 request in the same cycle with the macro defined -> grant order is 0,1,0,1 over four reads with both req held; with the macro undefined -> m0 is granted all four.
REQ-031 m1 alone holds req for 3 back-to-back reads at 0x4, 0x8, 0xC -> three m1_rvalid pulses spaced exactly 3 cycles apart with the matching data.
REQ-032 resetn pulled low during WAIT, then released -> no rvalid is issued, all outputs read 0 immediately, and busy=0.
REQ-033 m0_addr changed from 0x20 to 0x40 one cycle after the grant -> mem_addr stays 0x20 and the returned data is from 0x20.
